// File: rtl/stage_instruction_fetch_pkg.sv
// stage_instruction_fetch_pkg: architectural constants shared by the fetch stage.
// The ARCH_DEFINES guard keeps the macros single-definition when other blocks
// carry the same definitions. Optional feature macro: FETCH_TIMEOUT_EN.
`ifndef ARCH_DEFINES
`define ARCH_DEFINES
`define NUM_STAGES 5
`define IR_TYPE_HI 31
`define IR_TYPE_LO 27
`define IR_RR0_HI  26
`define IR_RR0_LO  22
`define IR_RR1_HI  21
`define IR_RR1_LO  17
`define IR_WR_HI   16
`define IR_WR_LO   12
`define NOP_TYPE   5'd0
`endif

package stage_instruction_fetch_pkg;
  localparam int NUM_STAGES = `NUM_STAGES;
  localparam int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int IR_W       = 32;
  localparam int FIELD_W    = 5;

  localparam int TYPE_HI = `IR_TYPE_HI;
  localparam int TYPE_LO = `IR_TYPE_LO;
  localparam int RR0_HI  = `IR_RR0_HI;
  localparam int RR0_LO  = `IR_RR0_LO;
  localparam int RR1_HI  = `IR_RR1_HI;
  localparam int RR1_LO  = `IR_RR1_LO;
  localparam int WR_HI   = `IR_WR_HI;
  localparam int WR_LO   = `IR_WR_LO;

  localparam logic [FIELD_W-1:0] NOP_TYPE = `NOP_TYPE;
  // A timed-out fetch loads this word: NOP type, every register field 0.
  localparam logic [IR_W-1:0]    NOP_WORD = {NOP_TYPE, {(IR_W-FIELD_W){1'b0}}};

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    EXEC       = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FIELD_W-1:0] itype;
    logic [FIELD_W-1:0] rr0;
    logic [FIELD_W-1:0] rr1;
    logic [FIELD_W-1:0] wr;
  } decode_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: pure field extraction from the instruction register, no extension.
module instr_decode
  import stage_instruction_fetch_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output decode_t         dec
);
  // slice the fixed fields; low bits below write_reg carry no decode
  always_comb begin
    dec       = '0;
    dec.itype = ir[TYPE_HI:TYPE_LO];
    dec.rr0   = ir[RR0_HI:RR0_LO];
    dec.rr1   = ir[RR1_HI:RR1_LO];
    dec.wr    = ir[WR_HI:WR_LO];
  end

  logic unused_ir_low;
  assign unused_ir_low = ^ir[WR_LO-1:0];
endmodule

// File: rtl/reg_async_reset.sv
// reg_async_reset: enabled register, asynchronously cleared by active-high rst.
module reg_async_reset #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;

  // hold unless enabled
  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // storage, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/stage_instruction_fetch.sv
// stage_instruction_fetch: fetch over req/ack, latch IR, decode, then step
// current_stage through the multi-cycle pipeline. With FETCH_TIMEOUT_EN a missing
// ack is replaced by a NOP after TIMEOUT_CYCLES and fetch_error is latched.
module stage_instruction_fetch
  import stage_instruction_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [4:0]         current_instruction_type,
  output logic [4:0]         read_reg_0,
  output logic [4:0]         read_reg_1,
  output logic [4:0]         write_reg,
  output logic [STAGE_W-1:0] current_stage,
  output logic               instr_valid
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic               fetch_error
`endif
);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1);

  fetch_state_t        state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic                valid_q, valid_d;
  logic                ir_en;
  logic [IR_W-1:0]     ir_d, ir_q;
  decode_t             dec;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // next-state, stage counter and IR load control
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    valid_d = valid_q;
    ir_en   = 1'b0;
    ir_d    = imem_rdata;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    case (state_q)
      RESET_WAIT: begin
        // any ack seen here belongs to a fetch aborted by reset
        stage_d = '0;
        valid_d = 1'b0;
        state_d = FETCH;
      end
      FETCH: begin
        stage_d = '0;
        if (imem_ack) begin
          ir_en   = 1'b1;
          valid_d = 1'b1;
          stage_d = STAGE_ONE;
          state_d = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          // this cycle would make TIMEOUT_CYCLES without ack: run a NOP instead
          ir_en   = 1'b1;
          ir_d    = NOP_WORD;
          valid_d = 1'b1;
          stage_d = STAGE_ONE;
          err_d   = 1'b1;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      EXEC: begin
        if (stage_q == LAST_STAGE) begin
          stage_d = '0;
          valid_d = 1'b0;
          state_d = FETCH;
        end else begin
          stage_d = stage_q + STAGE_ONE;
        end
      end
      default: begin
        stage_d = '0;
        valid_d = 1'b0;
        state_d = RESET_WAIT;
      end
    endcase
  end

  // control state; reset aborts any outstanding fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_WAIT;
      stage_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // ack wait counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_error = err_q;
`endif

  reg_async_reset #(.WIDTH(IR_W)) u_ir (
    .clk (clk),
    .rst (rst),
    .en  (ir_en),
    .d   (ir_d),
    .q   (ir_q)
  );

  instr_decode u_dec (
    .ir  (ir_q),
    .dec (dec)
  );

  // request is a pure state decode; address follows pc directly
  assign imem_req                 = (state_q == FETCH);
  assign imem_addr                = pc;
  assign current_instruction_type = dec.itype;
  assign read_reg_0               = dec.rr0;
  assign read_reg_1               = dec.rr1;
  assign write_reg                = dec.wr;
  assign current_stage            = stage_q;
  assign instr_valid              = valid_q;
endmodule

// File: tb/tb_stage_instruction_fetch.sv
// tb_stage_instruction_fetch: directed checks of reset, zero/wait-state fetch,
// stage wrap, ignored acks, mid-fetch reset and (with FETCH_TIMEOUT_EN) timeout.
module tb_stage_instruction_fetch;
  import stage_instruction_fetch_pkg::*;

  logic               clk;
  logic               rst;
  logic [31:0]        pc;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic [4:0]         itype, rr0, rr1, wr;
  logic [STAGE_W-1:0] stage;
  logic               ivalid;
`ifdef FETCH_TIMEOUT_EN
  logic               ferr;
`endif

  int total = 0;
  int bad   = 0;

  stage_instruction_fetch #(.TIMEOUT_CYCLES(8)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .pc                       (pc),
    .imem_req                 (imem_req),
    .imem_addr                (imem_addr),
    .imem_ack                 (imem_ack),
    .imem_rdata               (imem_rdata),
    .current_instruction_type (itype),
    .read_reg_0               (rr0),
    .read_reg_1               (rr1),
    .write_reg                (wr),
    .current_stage            (stage),
    .instr_valid              (ivalid)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_error              (ferr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] addr);
    chk({tag, "_req"},   32'(imem_req), 32'd1);
    chk({tag, "_addr"},  imem_addr,     addr);
    chk({tag, "_stage"}, 32'(stage),    32'd0);
  endtask

  task automatic chk_dec(input string tag, input int t, input int r0, input int r1, input int w);
    chk({tag, "_type"}, 32'(itype), 32'(t));
    chk({tag, "_rr0"},  32'(rr0),   32'(r0));
    chk({tag, "_rr1"},  32'(rr1),   32'(r1));
    chk({tag, "_wr"},   32'(wr),    32'(w));
  endtask

  initial begin
    rst = 1'b1; pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;

    // reset held 3 cycles: everything 0
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_stage", 32'(stage),    32'd0);
      chk("rst_valid", 32'(ivalid),   32'd0);
      chk_dec("rst", 0, 0, 0, 0);
`ifdef FETCH_TIMEOUT_EN
      chk("rst_ferr", 32'(ferr), 32'd0);
`endif
    end
    rst = 1'b0; pc = 32'h10;
    #1 chk("rw_req", 32'(imem_req), 32'd0);
    step();
    chk_fetch("first_fetch", 32'h10);

    // zero-wait fetch
    imem_ack = 1'b1; imem_rdata = 32'h2A8A_2000;
    step();
    imem_ack = 1'b0;
    chk_dec("zw", 5, 10, 5, 2);
    chk("zw_stage", 32'(stage),    32'd1);
    chk("zw_valid", 32'(ivalid),   32'd1);
    chk("zw_req",   32'(imem_req), 32'd0);

    // stage walk and wrap
    for (int s = 2; s < NUM_STAGES; s++) begin
      step();
      chk("walk_stage", 32'(stage), 32'(s));
      chk("walk_req",   32'(imem_req), 32'd0);
    end
    pc = 32'h20;
    step();
    chk_fetch("wrap", 32'h20);
    chk("wrap_valid", 32'(ivalid), 32'd0);
    chk_dec("wrap_hold", 5, 10, 5, 2);

    // wait-state fetch: ack in the 5th FETCH cycle
    for (int i = 0; i < 4; i++) begin
      chk_fetch("wait", 32'h20);
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'h8C6A_5000;
    #1 chk_fetch("wait_ack", 32'h20);
    step();
    imem_ack = 1'b0;
    chk_dec("ws", 17, 17, 21, 5);
    chk("ws_stage", 32'(stage), 32'd1);

    // ack during EXEC is ignored
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_ack = 1'b0;
    chk_dec("exec_ack", 17, 17, 21, 5);
    chk("exec_ack_stage", 32'(stage), 32'd2);
    for (int i = 0; i < NUM_STAGES - 2; i++) step();
    pc = 32'h30;
    chk_fetch("refetch", 32'h30);

    // reset mid-fetch, then a late ack in RESET_WAIT
    step();
    rst = 1'b1;
    #1;
    chk("midrst_req",   32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(ivalid),   32'd0);
    chk_dec("midrst", 0, 0, 0, 0);
    step();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2A8A_2000;
    step();
    imem_ack = 1'b0;
    chk_dec("late_ack", 0, 0, 0, 0);
    chk("late_ack_valid", 32'(ivalid), 32'd0);
    chk_fetch("late_ack", 32'h30);

    // normal fetch after reset recovery
    imem_ack = 1'b1; imem_rdata = 32'h2A8A_2000;
    step();
    imem_ack = 1'b0;
    chk_dec("recover", 5, 10, 5, 2);
    for (int i = 0; i < NUM_STAGES - 1; i++) step();
    chk_fetch("recover_wrap", 32'h30);

`ifdef FETCH_TIMEOUT_EN
    // no ack: 8 FETCH cycles then NOP with sticky error
    chk("tmo_ferr0", 32'(ferr), 32'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("tmo_wait_req", 32'(imem_req), 32'd1);
    end
    step();
    chk("tmo_req",   32'(imem_req), 32'd0);
    chk("tmo_stage", 32'(stage),    32'd1);
    chk("tmo_ferr",  32'(ferr),     32'd1);
    chk_dec("tmo", 0, 0, 0, 0);
    for (int i = 0; i < NUM_STAGES - 1; i++) step();
    chk_fetch("tmo_wrap", 32'h30);
    imem_ack = 1'b1; imem_rdata = 32'h2A8A_2000;
    step();
    imem_ack = 1'b0;
    chk_dec("post_tmo", 5, 10, 5, 2);
    chk("post_tmo_ferr", 32'(ferr), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stage_instruction_fetch.md
# stage_instruction_fetch

Instruction-fetch and stage-sequencing block that feeds `stage_pc_update`. It reads the current PC and fetches the instruction word from instruction memory over a req/ack handshake. It latches the word into an instruction register and decodes the instruction type and register addresses. It then steps `current_stage` through the remaining stages of the multi-cycle pipeline before fetching again.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: ack wait limit; used only when `FETCH_TIMEOUT_EN` is defined.

Ports:
- `clk`  input  1  clock. One clock; all state is clocked on its rising edge.
- `rst`  input  1  reset. Asynchronous, active-high.
- `pc`  input  32  current PC; connects to `PC_output` of `stage_pc_update`.
- `imem_req`  output  1  fetch request.
- `imem_addr`  output  32  fetch address.
- `imem_ack`  input  1  read data valid.
- `imem_rdata`  input  32  instruction word.
- `current_instruction_type`  output  5  equals IR[31:27].
- `read_reg_0`  output  5  equals IR[26:22]; register file port 0 (jump condition).
- `read_reg_1`  output  5  equals IR[21:17]; register file port 1 (jump address).
- `write_reg`  output  5  equals IR[16:12].
- `current_stage`  output  `$clog2(`NUM_STAGES)`  pipeline stage index.
- `instr_valid`  output  1  IR holds a fetched instruction.
- `fetch_error`  output  1  sticky timeout flag; exists only with `FETCH_TIMEOUT_EN`.

## Operation
- FSM has three states: RESET_WAIT, FETCH and EXEC.
- RESET_WAIT:
  - Entered on `rst`.
  - Lasts exactly one cycle after `rst` deasserts, then goes to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until ack.
  - `current_stage`=0.
  - On `imem_ack`=1: IR <= `imem_rdata`, `instr_valid` <= 1, current_stage <= 1, go to EXEC.
  - An ack while `imem_req`=0 is ignored.
- EXEC:
  - `imem_req`=0.
  - `current_stage` increments by 1 each cycle.
  - When `current_stage` = `NUM_STAGES`-1: next cycle current_stage <= 0, `instr_valid` <= 0, go to FETCH.
  - The stage counter never exceeds `NUM_STAGES`-1; it wraps to 0 exactly at the last stage.
- IR holds its value through EXEC and the following FETCH until the next ack. Decoded outputs therefore stay stable while `stage_pc_update` computes the new PC.
- Decode is purely combinational from IR. It has no width extension.
- Reset values: IR=0, so `current_instruction_type`, `read_reg_0`, `read_reg_1` and `write_reg` are all 0. `current_stage`=0, `imem_req`=0, `instr_valid`=0, `fetch_error`=0.
- Reset mid-operation aborts any outstanding fetch. A late ack arriving in RESET_WAIT is ignored.

## Timing
- Fetch latency is 1 + N cycles from FETCH entry, where N is the cycle ack arrives. N=0 (ack in the same cycle as req) is legal.
- Decoded outputs are valid the cycle after ack.
- A full instruction takes (fetch wait cycles) + `NUM_STAGES`-1 EXEC cycles.
- `imem_addr` is registered-free: it is combinational from `pc`. `pc` must not change during FETCH; `stage_pc_update` only enables the PC in EXEC stages.

## Configuration
`FETCH_TIMEOUT_EN`:
- Defined:
  - A wait counter (width `$clog2(TIMEOUT_CYCLES+1)`) counts FETCH cycles without ack.
  - When it reaches `TIMEOUT_CYCLES`: IR <= 0 (NOP, type 0), `fetch_error` <= 1 (sticky until `rst`), go to EXEC.
  - The counter clears on FETCH entry.
- Undefined: no counter and no `fetch_error` port. FETCH waits indefinitely.

## Structure
- Shared definitions come from `arch_defines.v`, guarded by `ARCH_DEFINES`: `NUM_STAGES`, the instruction field bit positions, and the NOP type code (0).
- One sub-module, `instr_decode`, handles IR field extraction. The FSM, IR and counters live in the top module.
- The IR uses `reg_async_reset` with width 32, enabled on ack.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs 0. One cycle after release → `imem_req`=1, `imem_addr`=`pc`.
- Zero-wait fetch: `pc`=0x10, ack the same cycle with rdata=0x2A8A2000 → next cycle type=5, read_reg_0=10, read_reg_1=5, write_reg=2, `current_stage`=1.
- Wait-state fetch: ack after 4 cycles → `imem_req` and `imem_addr` held for all 5 cycles, `current_stage`=0 throughout.
- Stage wrap: after ack, `current_stage` runs 1..`NUM_STAGES`-1 → then returns to 0 with `imem_req`=1 and `instr_valid`=0, while IR is unchanged.
- Reset mid-fetch: assert `rst` during a wait → `imem_req`=0 immediately. An ack asserted in RESET_WAIT does not load IR.
- `FETCH_TIMEOUT_EN` with `TIMEOUT_CYCLES`=8: no ack → after 8 cycles type=0, `fetch_error`=1, EXEC runs. `fetch_error` stays 1 on subsequent good fetches.
